// File: rtl/desc_fetch_arbiter.sv
// Descriptor-fetch AR arbiter: round-robin merges per-channel AR requests into
// one master AR port, tracks outstanding bursts per channel and routes R beats
// back to their owner by AXI ID.
module desc_fetch_arbiter #(
    parameter int unsigned NUM_CHANNELS    = 8,
    parameter int unsigned CHAN_WIDTH      = $clog2(NUM_CHANNELS),
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned AXI_ID_WIDTH    = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS-1:0]            ch_ar_valid,
    output logic [NUM_CHANNELS-1:0]            ch_ar_ready,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_ar_addr,
    input  logic [NUM_CHANNELS*8-1:0]          ch_ar_len,
    output logic [NUM_CHANNELS-1:0]            ch_r_valid,
    input  logic [NUM_CHANNELS-1:0]            ch_r_ready,
    output logic [255:0]                       ch_r_data,
    output logic [1:0]                         ch_r_resp,
    output logic                               ch_r_last,
    output logic                               m_ar_valid,
    output logic [ADDR_WIDTH-1:0]              m_ar_addr,
    output logic [7:0]                         m_ar_len,
    output logic [AXI_ID_WIDTH-1:0]            m_ar_id,
    input  logic                               m_ar_ready,
    input  logic                               m_r_valid,
    input  logic [255:0]                       m_r_data,
    input  logic [1:0]                         m_r_resp,
    input  logic                               m_r_last,
    input  logic [AXI_ID_WIDTH-1:0]            m_r_id,
    output logic                               m_r_ready,
    input  logic [NUM_CHANNELS-1:0]            cfg_channel_reset,
    input  logic                               err_clear,
    output logic [NUM_CHANNELS*4-1:0]          ch_outstanding,
    output logic [NUM_CHANNELS-1:0]            ch_idle,
    output logic                               all_idle,
    output logic                               err_unknown_id,
    output logic                               err_underflow
);

    localparam int unsigned CNT_W = 4;

    if (NUM_CHANNELS < 2 || NUM_CHANNELS > 32) begin : g_bad_num_channels
        $error("desc_fetch_arbiter: NUM_CHANNELS must be 2..32");
    end
    if (AXI_ID_WIDTH < CHAN_WIDTH) begin : g_bad_id_width
        $error("desc_fetch_arbiter: AXI_ID_WIDTH must be >= CHAN_WIDTH");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_outstanding
        $error("desc_fetch_arbiter: MAX_OUTSTANDING must be 1..15");
    end

    logic [CNT_W-1:0]        cnt_q [NUM_CHANNELS];
    logic [CNT_W-1:0]        cnt_d [NUM_CHANNELS];
    logic                    ar_valid_q, ar_valid_d;
    logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
    logic [7:0]              ar_len_q, ar_len_d;
    logic [AXI_ID_WIDTH-1:0] ar_id_q, ar_id_d;
    logic [CHAN_WIDTH-1:0]   rr_q, rr_d;
    logic                    err_uid_q, err_uid_d;
    logic                    err_uf_q, err_uf_d;

    logic [NUM_CHANNELS-1:0] elig;
    logic [CHAN_WIDTH-1:0]   grant;
    logic                    grant_found;
    logic                    ar_hs;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [7:0]              sel_len;
    int unsigned             best_dist, cur_dist, rr_u;

    logic [CHAN_WIDTH-1:0]   r_chan;
    logic                    r_known;
    logic                    r_hs;
    logic                    r_dec;
    logic                    uf_set;
    logic                    unused_id_bits;

    // Round-robin pick: eligible channel closest to rr_q going upward, with wrap
    always_comb begin
        elig        = '0;
        grant       = '0;
        best_dist   = NUM_CHANNELS;
        rr_u        = 32'(rr_q);
        cur_dist    = 0;
        sel_addr    = '0;
        sel_len     = '0;
        ch_ar_ready = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            elig[i]  = ch_ar_valid[i] & ~cfg_channel_reset[i] &
                       (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
            cur_dist = (i + NUM_CHANNELS - rr_u) % NUM_CHANNELS;
            if (elig[i] && (cur_dist < best_dist)) begin
                best_dist = cur_dist;
                grant     = CHAN_WIDTH'(i);
            end
        end
        grant_found = (best_dist < NUM_CHANNELS);
        ar_hs       = grant_found & (~ar_valid_q | m_ar_ready) & ~rst;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (grant == CHAN_WIDTH'(i)) begin
                sel_addr = ch_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = ch_ar_len[i*8 +: 8];
            end
            ch_ar_ready[i] = ar_hs & (grant == CHAN_WIDTH'(i));
        end
    end

    // R routing: known, non-quiesced channels get the beat; everything else is sunk
    always_comb begin
        r_chan     = m_r_id[CHAN_WIDTH-1:0];
        r_known    = 1'b0;
        ch_r_valid = '0;
        m_r_ready  = 1'b1;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (r_chan == CHAN_WIDTH'(i)) begin
                r_known = 1'b1;
                if (!cfg_channel_reset[i]) begin
                    ch_r_valid[i] = m_r_valid;
                    m_r_ready     = ch_r_ready[i];
                end
            end
        end
        r_hs  = m_r_valid & m_r_ready;
        r_dec = r_hs & m_r_last & r_known;
    end

    assign ch_r_data      = m_r_data;
    assign ch_r_resp      = m_r_resp;
    assign ch_r_last      = m_r_last;
    assign unused_id_bits = ^m_r_id;

    // Next state: AR register, rr pointer, outstanding counters, sticky errors
    always_comb begin
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_id_d    = ar_id_q;
        rr_d       = rr_q;
        uf_set     = 1'b0;
        if (ar_hs) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = sel_addr;
            ar_len_d   = sel_len;
            ar_id_d    = AXI_ID_WIDTH'(grant);
            rr_d       = CHAN_WIDTH'((32'(grant) + 32'd1) % NUM_CHANNELS);
        end else if (m_ar_ready) begin
            ar_valid_d = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            // Simultaneous issue and completion on one channel cancel out
            if (ar_hs && (grant == CHAN_WIDTH'(i)) && !(r_dec && (r_chan == CHAN_WIDTH'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (r_dec && (r_chan == CHAN_WIDTH'(i)) && !(ar_hs && (grant == CHAN_WIDTH'(i)))) begin
                if (cnt_q[i] == '0) begin
                    uf_set = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
        err_uid_d = (r_hs & ~r_known) ? 1'b1 : (err_clear ? 1'b0 : err_uid_q);
        err_uf_d  = uf_set ? 1'b1 : (err_clear ? 1'b0 : err_uf_q);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_id_q    <= '0;
            rr_q       <= '0;
            err_uid_q  <= 1'b0;
            err_uf_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_id_q    <= ar_id_d;
            rr_q       <= rr_d;
            err_uid_q  <= err_uid_d;
            err_uf_q   <= err_uf_d;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Status: a channel is idle when nothing is in flight or queued for issue
    always_comb begin
        ch_outstanding = '0;
        ch_idle        = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            ch_outstanding[i*4 +: 4] = cnt_q[i];
            ch_idle[i] = (cnt_q[i] == '0) & ~(ar_valid_q & (ar_id_q == AXI_ID_WIDTH'(i)));
        end
        all_idle = &ch_idle;
    end

    assign m_ar_valid     = ar_valid_q;
    assign m_ar_addr      = ar_addr_q;
    assign m_ar_len       = ar_len_q;
    assign m_ar_id        = ar_id_q;
    assign err_unknown_id = err_uid_q;
    assign err_underflow  = err_uf_q;

endmodule

// File: tb/tb_desc_fetch_arbiter.sv
// Bench for desc_fetch_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_desc_fetch_arbiter;

    localparam int N   = 8;
    localparam int CW  = 4;   // wider than needed so IDs 8..15 decode as unknown
    localparam int AW  = 32;
    localparam int IDW = 8;
    localparam int MAX = 2;

    logic            clk, rst;
    logic [N-1:0]    ch_ar_valid, ch_ar_ready, ch_r_valid, ch_r_ready;
    logic [N*AW-1:0] ch_ar_addr;
    logic [N*8-1:0]  ch_ar_len;
    logic [255:0]    ch_r_data, m_r_data;
    logic [1:0]      ch_r_resp, m_r_resp;
    logic            ch_r_last, m_r_last;
    logic            m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [AW-1:0]   m_ar_addr;
    logic [7:0]      m_ar_len;
    logic [IDW-1:0]  m_ar_id, m_r_id;
    logic [N-1:0]    cfg_channel_reset, ch_idle;
    logic            err_clear, all_idle, err_unknown_id, err_underflow;
    logic [N*4-1:0]  ch_outstanding;

    desc_fetch_arbiter #(
        .NUM_CHANNELS(N), .CHAN_WIDTH(CW), .ADDR_WIDTH(AW),
        .AXI_ID_WIDTH(IDW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_ar_valid(ch_ar_valid), .ch_ar_ready(ch_ar_ready),
        .ch_ar_addr(ch_ar_addr), .ch_ar_len(ch_ar_len),
        .ch_r_valid(ch_r_valid), .ch_r_ready(ch_r_ready),
        .ch_r_data(ch_r_data), .ch_r_resp(ch_r_resp), .ch_r_last(ch_r_last),
        .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
        .m_ar_id(m_ar_id), .m_ar_ready(m_ar_ready),
        .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
        .m_r_last(m_r_last), .m_r_id(m_r_id), .m_r_ready(m_r_ready),
        .cfg_channel_reset(cfg_channel_reset), .err_clear(err_clear),
        .ch_outstanding(ch_outstanding), .ch_idle(ch_idle), .all_idle(all_idle),
        .err_unknown_id(err_unknown_id), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: in-flight bursts, pending AR, pointer, errors
    int          mcnt [N];
    bit          marv;
    int          mid;
    logic [31:0] maddr;
    logic [7:0]  mlen;
    int          mrr;
    bit          meu, mef;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        marv = 0; mid = 0; maddr = '0; mlen = '0; mrr = 0; meu = 0; mef = 0;
    endtask

    // Compare DUT against model for the current inputs, then advance the model
    task automatic step();
        int g, c, idx, inc_ch, dec_ch;
        bit can, hs, known, routed, e_mrr, rhs, uf;
        logic [N-1:0] e_arr, e_rv, e_idle;
        logic [N*4-1:0] e_out;
        if (rst) begin
            chk("ar_ready_in_rst", ch_ar_ready, '0);
            model_reset();
            return;
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (mrr + k) % N;
            if (g < 0 && ch_ar_valid[idx] && !cfg_channel_reset[idx] && mcnt[idx] < MAX) g = idx;
        end
        can   = !marv || m_ar_ready;
        hs    = (g >= 0) && can;
        e_arr = '0;
        if (hs) e_arr[g] = 1'b1;
        c      = int'(m_r_id[CW-1:0]);
        known  = (c < N);
        routed = known ? !cfg_channel_reset[c] : 1'b0;
        e_rv   = '0;
        if (routed && m_r_valid) e_rv[c] = 1'b1;
        e_mrr  = routed ? ch_r_ready[c] : 1'b1;
        for (int i = 0; i < N; i++) begin
            e_out[i*4 +: 4] = 4'(mcnt[i]);
            e_idle[i] = (mcnt[i] == 0) && !(marv && mid == i);
        end
        chk("ch_ar_ready", ch_ar_ready, e_arr);
        chk("ch_r_valid", ch_r_valid, e_rv);
        chk("m_r_ready", m_r_ready, e_mrr);
        chk("ch_r_data", {ch_r_data}, m_r_data);
        chk("ch_r_last_resp", {ch_r_last, ch_r_resp}, {m_r_last, m_r_resp});
        chk("m_ar_valid", m_ar_valid, marv);
        if (marv) begin
            chk("m_ar_id", m_ar_id, 8'(mid));
            chk("m_ar_addr", m_ar_addr, maddr);
            chk("m_ar_len", m_ar_len, mlen);
        end
        chk("ch_outstanding", ch_outstanding, e_out);
        chk("ch_idle", ch_idle, e_idle);
        chk("all_idle", all_idle, &e_idle);
        chk("err_unknown_id", err_unknown_id, meu);
        chk("err_underflow", err_underflow, mef);
        // advance
        if (hs) begin
            marv = 1; mid = g;
            maddr = ch_ar_addr[g*AW +: AW];
            mlen  = ch_ar_len[g*8 +: 8];
            mrr   = (g + 1) % N;
        end else if (m_ar_ready) begin
            marv = 0;
        end
        rhs    = m_r_valid && e_mrr;
        inc_ch = hs ? g : -1;
        dec_ch = (rhs && m_r_last && known) ? c : -1;
        uf     = 0;
        if (inc_ch != dec_ch) begin
            if (inc_ch >= 0) mcnt[inc_ch]++;
            if (dec_ch >= 0) begin
                if (mcnt[dec_ch] == 0) uf = 1;
                else mcnt[dec_ch]--;
            end
        end
        meu = (rhs && !known) ? 1'b1 : (err_clear ? 1'b0 : meu);
        mef = uf ? 1'b1 : (err_clear ? 1'b0 : mef);
    endtask

    task automatic eval(); #1; step(); endtask
    task automatic nxt();  @(negedge clk); endtask
    task automatic cyc();  eval(); nxt(); endtask

    task automatic set_addrs();
        for (int i = 0; i < N; i++) begin
            ch_ar_addr[i*AW +: AW] = 32'hA5A5_0000 | 32'(i);
            ch_ar_len[i*8 +: 8]    = 8'(i*3 + 1);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; ch_ar_valid = '0; ch_r_ready = '1; m_ar_ready = 1;
        m_r_valid = 0; m_r_last = 0; m_r_id = '0; m_r_resp = 2'(1);
        m_r_data = {8{$urandom}}; cfg_channel_reset = '0; err_clear = 0;
    endtask

    // Return a final beat for every burst the model still holds, then clear errors
    task automatic drain();
        idle_inputs();
        cyc();
        for (int ch = 0; ch < N; ch++) begin
            for (int guard = 0; guard < 20 && mcnt[ch] > 0; guard++) begin
                m_r_valid = 1; m_r_id = 8'(ch); m_r_last = 1;
                cyc();
            end
        end
        idle_inputs();
        err_clear = 1; cyc();
        err_clear = 0; cyc();
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        model_reset();
        idle_inputs();
        set_addrs();
        rst = 1;
        nxt(); cyc(); cyc();
        rst = 0;

        // reset exit state
        eval();
        chk("rst_ch_idle", ch_idle, 8'hFF);
        chk("rst_all_idle", all_idle, 1'b1);
        chk("rst_ar_valid", m_ar_valid, 1'b0);
        nxt();

        // round robin over channels 0..3
        ch_ar_valid = 8'h0F;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) ch_ar_valid = '0;
            eval();
            if (k >= 1) begin
                chk("rr_valid", m_ar_valid, 1'b1);
                chk("rr_id", m_ar_id, 8'(rr_exp[k-1]));
            end
            nxt();
        end
        drain();

        // outstanding limit on channel 1
        ch_ar_valid = 8'h02;
        cyc(); cyc();
        eval();
        chk("lim_ready", ch_ar_ready[1], 1'b0);
        chk("lim_cnt", ch_outstanding[7:4], 4'd2);
        nxt();
        m_r_valid = 1; m_r_id = 8'd1; m_r_last = 1;
        eval(); chk("lim_ready_r", ch_ar_ready[1], 1'b0); nxt();
        m_r_valid = 0;
        eval(); chk("lim_reissue", ch_ar_ready[1], 1'b1); nxt();
        drain();

        // simultaneous issue and completion on channel 2
        ch_ar_valid = 8'h04;
        cyc();
        m_r_valid = 1; m_r_id = 8'd2; m_r_last = 1;
        eval();
        chk("sim_ready", ch_ar_ready, 8'h04);
        chk("sim_cnt_pre", ch_outstanding[11:8], 4'd1);
        nxt();
        ch_ar_valid = '0; m_r_valid = 0;
        eval(); chk("sim_cnt", ch_outstanding[11:8], 4'd1); nxt();
        drain();

        // quiesce channel 3 while its burst drains
        ch_ar_valid = 8'h08;
        cyc();
        ch_ar_valid = '0; cfg_channel_reset = 8'h08; ch_r_ready = '0;
        for (int b = 0; b < 4; b++) begin
            m_r_valid = 1; m_r_id = 8'd3; m_r_last = (b == 3);
            eval();
            chk("drain_rv", ch_r_valid[3], 1'b0);
            chk("drain_rdy", m_r_ready, 1'b1);
            nxt();
        end
        m_r_valid = 0;
        eval(); chk("drain_idle", ch_idle[3], 1'b1); nxt();
        drain();

        // unknown ID and underflow
        m_r_valid = 1; m_r_id = 8'd9; m_r_last = 1;
        eval();
        chk("unk_rdy", m_r_ready, 1'b1);
        chk("unk_rv", ch_r_valid, 8'h00);
        nxt();
        m_r_valid = 0;
        eval(); chk("unk_err", err_unknown_id, 1'b1); nxt();
        err_clear = 1; cyc(); err_clear = 0;
        eval(); chk("unk_clr", err_unknown_id, 1'b0); nxt();
        m_r_valid = 1; m_r_id = 8'd0; m_r_last = 1;
        cyc();
        m_r_valid = 0;
        eval();
        chk("uf_err", err_underflow, 1'b1);
        chk("uf_cnt", ch_outstanding[3:0], 4'd0);
        nxt();
        drain();

        // master backpressure holds the pending AR
        m_ar_ready = 0; ch_ar_valid = 8'h20;
        cyc();
        ch_ar_valid = 8'h60;
        for (int k = 0; k < 5; k++) begin
            eval();
            chk("bp_ready", ch_ar_ready, 8'h00);
            chk("bp_valid", m_ar_valid, 1'b1);
            chk("bp_addr", m_ar_addr, 32'hA5A5_0005);
            chk("bp_len", m_ar_len, 8'd16);
            chk("bp_id", m_ar_id, 8'd5);
            nxt();
        end
        drain();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            ch_ar_valid  = 8'($urandom);
            ch_ar_addr   = {8{$urandom}};
            ch_ar_len    = {2{$urandom}};
            m_ar_ready   = ($urandom_range(0, 3) != 0);
            m_r_valid    = $urandom_range(0, 1) == 1;
            m_r_last     = $urandom_range(0, 1) == 1;
            m_r_id       = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 15)) : 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) m_r_id[7:4] = 4'($urandom);
            m_r_data     = {8{$urandom}};
            m_r_resp     = 2'($urandom);
            ch_r_ready   = 8'($urandom);
            cfg_channel_reset = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            err_clear    = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/desc_fetch_arbiter.md
DESC_FETCH_ARBITER -- requirements
Module: desc_fetch_arbiter

Interface
REQ-001 SHALL take parameter NUM_CHANNELS, default 8: number of descriptor-engine clients; legal range 2..32.
REQ-002 SHALL take parameter CHAN_WIDTH, default $clog2(NUM_CHANNELS): channel index width.
REQ-003 SHALL take parameter ADDR_WIDTH, default 64: AR address width.
REQ-004 SHALL take parameter AXI_ID_WIDTH, default 8: master ID width; elaboration error if less than CHAN_WIDTH.
REQ-005 SHALL take parameter MAX_OUTSTANDING, default 4: per-channel AR bursts in flight; legal range 1..15.
REQ-006 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset), listed first.
REQ-007 SHALL have ch_ar_valid (in, N), ch_ar_ready (out, N), ch_ar_addr (in, N*ADDR_WIDTH) and ch_ar_len (in, N*8); channel i occupies slice i.
REQ-008 SHALL have ch_r_valid (out, N) and ch_r_ready (in, N); ch_r_data (out, 256), ch_r_resp (out, 2) and ch_r_last (out, 1) broadcast to all channels.
REQ-009 SHALL have master AR outputs m_ar_valid (1), m_ar_addr (ADDR_WIDTH), m_ar_len (8) and m_ar_id (AXI_ID_WIDTH), plus input m_ar_ready (1).
REQ-010 SHALL have master R inputs m_r_valid (1), m_r_data (256), m_r_resp (2), m_r_last (1) and m_r_id (AXI_ID_WIDTH), plus output m_r_ready (1).
REQ-011 SHALL have cfg_channel_reset (in, N): per-channel quiesce request.
REQ-012 SHALL have err_clear (in, 1): single-cycle clear of sticky errors.
REQ-013 SHALL have status outputs ch_outstanding (out, N*4), ch_idle (out, N), all_idle (out, 1), err_unknown_id (out, 1, sticky) and err_underflow (out, 1, sticky).

Function
REQ-014 SHALL hold a single-entry AR output register; eligible channel i: ch_ar_valid[i] & !cfg_channel_reset[i] & outstanding[i] < MAX_OUTSTANDING.
REQ-015 SHALL grant the first eligible channel at or after rr_ptr, wrapping modulo NUM_CHANNELS.
REQ-016 SHALL assert ch_ar_ready[i] combinationally only for the granted channel and only when (!m_ar_valid | m_ar_ready); at most one bit high per cycle.
REQ-017 SHALL load the granted payload on the ch handshake, with m_ar_valid rising the next cycle; latency is one cycle from ch_ar_valid to m_ar_valid when the register is empty.
REQ-018 SHALL keep m_ar_addr, m_ar_len and m_ar_id stable while m_ar_valid & !m_ar_ready.
REQ-019 SHALL drive m_ar_id as the channel index zero-extended to AXI_ID_WIDTH.
REQ-020 SHALL set rr_ptr to (granted+1) mod NUM_CHANNELS on each ch handshake, and leave it unchanged otherwise.
REQ-021 SHALL support back-to-back grants: m_ar_ready and a new grant in the same cycle give full throughput, one AR per cycle.
REQ-022 SHALL increment outstanding[i] on the ch AR handshake for channel i.
REQ-023 SHALL decrement outstanding[i] on an m_r handshake with m_r_last and channel i.
REQ-024 SHALL leave outstanding[i] unchanged when the increment and decrement for channel i occur in the same cycle.
REQ-025 SHALL saturate outstanding[i] at 0 when a decrement arrives at zero, and set err_underflow.
REQ-026 SHALL decode the R channel index c = m_r_id[CHAN_WIDTH-1:0]; ID bits above CHAN_WIDTH are ignored.
REQ-027 SHALL route R combinationally for a valid c not in reset: ch_r_valid[c] = m_r_valid, all other ch_r_valid bits 0, m_r_ready = ch_r_ready[c], and ch_r_data/resp/last = m_r_data/resp/last.
REQ-028 SHALL sink beats with c >= NUM_CHANNELS (m_r_ready=1, no ch_r_valid) and set err_unknown_id on each such handshake.
REQ-029 SHALL, while cfg_channel_reset[c] is high, keep ch_r_valid[c]=0 and m_r_ready=1 so in-flight bursts drain, while outstanding still decrements.
REQ-030 SHALL NOT cancel an AR already loaded in the output register when cfg_channel_reset asserts; that AR still issues.
REQ-031 SHALL drive ch_idle[i] = (outstanding[i]==0) & !(m_ar_valid & m_ar_id==i), and all_idle = AND of ch_idle.
REQ-032 SHALL clear both sticky errors on err_clear, with a set in the same cycle taking priority.

Reset
REQ-033 SHALL, while rst is high at a clk edge, clear m_ar_valid, all outstanding counts, rr_ptr and both errors.
REQ-034 SHALL force ch_ar_ready=0 during reset and make ch_idle all ones and all_idle=1 the cycle after reset.
REQ-035 SHALL discard any in-flight AR register contents on reset, with no m_ar_valid glitch on the exit cycle.

Verification
REQ-036 SHALL verify round-robin: N=4, ch 0..3 valid continuously, m_ar_ready=1 -> m_ar_id sequence 0,1,2,3,0 on consecutive cycles.
REQ-037 SHALL verify the outstanding limit: MAX=2, ch1 requests 3 ARs with no R returned -> third ch_ar_ready[1] withheld and ch_outstanding[1]=2; one R last on ID 1 -> third AR issues.
REQ-038 SHALL verify a simultaneous event: ch2 AR accepted and an R last for ID 2 in the same cycle with outstanding=1 -> count stays 1.
REQ-039 SHALL verify channel reset drain: ch3 outstanding=1, assert cfg_channel_reset[3], 4-beat burst on ID 3 -> ch_r_valid[3] stays 0, m_r_ready=1 for all 4 beats, and ch_idle[3]=1 after the last beat.
REQ-040 SHALL verify error paths: R on ID 9 with N=8 -> beat sunk and err_unknown_id=1; err_clear -> 0 the next cycle. R last on ID 0 with outstanding=0 -> err_underflow=1 and count stays 0.
REQ-041 SHALL verify backpressure: m_ar_ready=0 for 5 cycles with m_ar_valid high -> payload stable and no ch_ar_ready asserted.
